// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - autobaud divisor measurement and 16x tick generator (optional UART_AUTOBAUD_INTERVAL_CHECK_EN)
module uart_autobaud #(
    parameter int CNT_W       = 20,
    parameter int DIV_W       = 12,
    parameter int DEFAULT_DIV = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             start,
    output logic             tick,
    output logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, STOP} state_t;

    state_t           state;
    logic             rx_meta, rx_sync, rx_prev;
    logic             fall, rise;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] c_span;
    logic [1:0]       edges;
    logic [DIV_W-1:0] cnt;
    logic [CNT_W:0]   sum_c;
    logic [CNT_W:0]   d_calc;
    logic             d_ok;
    logic             ivl_bad;

    assign fall = rx_prev & ~rx_sync;
    assign rise = ~rx_prev & rx_sync;

    assign sum_c  = {1'b0, c_span} + (CNT_W+1)'(64);
    assign d_calc = sum_c >> 7;
    assign d_ok   = (d_calc >= (CNT_W+1)'(2)) && ((d_calc >> DIV_W) == '0);

`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
    logic [CNT_W-1:0] intv, i1, ik, idiff;
    // ik counts the latch cycle itself, so it equals the true edge-to-edge distance
    assign ik      = intv + CNT_W'(1);
    assign idiff   = (ik > i1) ? (ik - i1) : (i1 - ik);
    assign ivl_bad = (edges != 2'd0) && (idiff > (i1 >> 2));
`else
    assign ivl_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            total   <= '0;
            c_span  <= '0;
            edges   <= '0;
            cnt     <= '0;
            tick    <= 1'b0;
            divisor <= DIV_W'(DEFAULT_DIV);
            busy    <= 1'b0;
            locked  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
            intv    <= '0;
            i1      <= '0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            done    <= 1'b0;
            err     <= 1'b0;

            tick <= (cnt == divisor - DIV_W'(1));
            if (cnt == divisor - DIV_W'(1)) cnt <= '0;
            else                            cnt <= cnt + DIV_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (fall) begin
                        total <= '0;
                        edges <= '0;
`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
                        intv  <= '0;
`endif
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    total <= total + CNT_W'(1);
`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
                    intv  <= fall ? '0 : intv + CNT_W'(1);
                    if (fall && edges == 2'd0) i1 <= ik;
`endif
                    if (&total || (fall && ivl_bad)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (fall) begin
                        edges <= edges + 2'd1;
                        // +1 includes the entry cycle so c_span is the exact 8-bit span
                        if (edges == 2'd3) begin
                            c_span <= total + CNT_W'(1);
                            state  <= STOP;
                        end
                    end
                end
                STOP: begin
                    total <= total + CNT_W'(1);
                    if (&total) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rise) begin
                        if (d_ok) begin
                            divisor <= DIV_W'(d_calc);
                            cnt     <= '0;
                            done    <= 1'b1;
                            locked  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb/tb_uart_autobaud.sv - self-checking bench for uart_autobaud against a timestamp-based model
module tb_uart_autobaud;

    localparam int MCW = 16;
    localparam int DEF = 27;
    localparam int SAT = (1 << MCW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx, start;
    logic        tick, busy, locked, done, err;
    logic [11:0] divisor;
    logic        rx_s, start_s;
    logic        tick_s, busy_s, locked_s, done_s, err_s;
    logic [11:0] div_s;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;

    always #5 clk = ~clk;

    uart_autobaud #(.CNT_W(MCW), .DIV_W(12), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .rx(rx), .start(start), .tick(tick),
        .divisor(divisor), .busy(busy), .locked(locked), .done(done), .err(err)
    );

    uart_autobaud #(.CNT_W(8), .DIV_W(12), .DEFAULT_DIV(DEF)) dut_s (
        .clk(clk), .reset(reset), .rx(rx_s), .start(start_s), .tick(tick_s),
        .divisor(div_s), .busy(busy_s), .locked(locked_s), .done(done_s), .err(err_s)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: line edges are timestamped in clk cycles; outputs follow from the timestamps.
    int n, next_tick, m_div, phase, t_first, t_last, nf, c_val, i1, ik, dd;
    bit m_tick, m_busy, m_locked, m_done, m_err, mfall, mrise, abort;
    bit h [0:3];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; next_tick = DEF; m_div = DEF; phase = 0; nf = 0;
            m_tick = 0; m_busy = 0; m_locked = 0; m_done = 0; m_err = 0;
            for (int i = 0; i < 4; i++) h[i] = 1'b1;
        end else begin
            n++;
            h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = rx;
            mfall = h[3] & ~h[2];
            mrise = ~h[3] & h[2];
            m_done = 0; m_err = 0; abort = 0;
            m_tick = (n == next_tick);
            if (m_tick) next_tick += m_div;
            case (phase)
                0: if (start) begin phase = 1; m_busy = 1; end
                1: if (mfall) begin t_first = n; t_last = n; nf = 0; phase = 2; end
                2: begin
                    if (n - t_first - 1 == SAT) abort = 1;
                    else if (mfall) begin
                        ik = n - t_last; t_last = n; nf++;
`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
                        if (nf == 1) i1 = ik;
                        else if ((ik > i1 ? ik - i1 : i1 - ik) > i1 / 4) abort = 1;
`endif
                        if (!abort && nf == 4) begin c_val = n - t_first; phase = 3; end
                    end
                end
                default: begin
                    if (n - t_first - 1 == SAT) abort = 1;
                    else if (mrise) begin
                        dd = (c_val + 64) / 128;
                        if (dd >= 2 && dd <= 4095) begin
                            m_div = dd; next_tick = n + dd; m_done = 1; m_locked = 1;
                        end else m_err = 1;
                        m_busy = 0; phase = 0;
                    end
                end
            endcase
            if (abort) begin m_err = 1; m_busy = 0; phase = 0; end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("tick", tick, m_tick);
            chk("divisor", divisor, m_div);
            chk("busy", busy, m_busy);
            chk("locked", locked, m_locked);
            chk("done", done, m_done);
            chk("err", err, m_err);
            if (err) err_seen++;
        end
    end

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] val, input int period, input bit mid_start);
        logic [9:0] frame;
        frame = {1'b1, val, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            if (mid_start && i == 4) begin
                start = 1'b1; @(negedge clk); start = 1'b0;
                repeat (period - 1) @(negedge clk);
            end else repeat (period) @(negedge clk);
        end
    endtask

    task automatic tick_gap(output int gap);
        int k, t0;
        k = 0;
        while (!tick && k < 2000) begin @(negedge clk); k++; end
        t0 = k;
        @(negedge clk); k++;
        while (!tick && k < 4000) begin @(negedge clk); k++; end
        gap = k - t0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, e0, sk, s_errs;
        rx = 1; start = 0; rx_s = 1; start_s = 0; reset = 1;
        repeat (3) @(negedge clk);
        chk("rst_tick", tick, 0);
        chk("rst_divisor", divisor, 27);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_done_err", {done, err}, 0);
        reset = 0;
        tick_gap(g);
        chk("default_tick_gap", g, 27);

        // All-zero character on the narrow-counter instance: total saturates
        start_s = 1; @(negedge clk); start_s = 0;
        repeat (3) @(negedge clk);
        chk("sat_busy", busy_s, 1);
        rx_s = 0;
        sk = 0; s_errs = 0;
        while (sk < 600) begin
            @(negedge clk); sk++;
            if (err_s) s_errs++;
        end
        rx_s = 1;
        chk("sat_err_pulses", s_errs, 1);
        chk("sat_divisor", div_s, 27);
        chk("sat_locked", locked_s, 0);
        chk("sat_busy_after", busy_s, 0);

        // 115200 baud with a second start mid-character
        pulse_start();
        repeat (5) @(negedge clk);
        send_char(8'h55, 434, 1'b1);
        repeat (10) @(negedge clk);
        chk("lock115k_divisor", divisor, 27);
        chk("lock115k_locked", locked, 1);
        tick_gap(g);
        chk("lock115k_gap", g, 27);

        // 9600 baud
        pulse_start();
        repeat (5) @(negedge clk);
        send_char(8'h55, 5208, 1'b0);
        repeat (10) @(negedge clk);
        chk("lock9600_divisor", divisor, 326);
        tick_gap(g);
        chk("lock9600_gap", g, 326);

        // Bit period too short: D=1 is rejected
        e0 = err_seen;
        pulse_start();
        repeat (5) @(negedge clk);
        send_char(8'h55, 10, 1'b0);
        repeat (10) @(negedge clk);
        chk("short_err", err_seen - e0, 1);
        chk("short_divisor", divisor, 326);

`ifdef UART_AUTOBAUD_INTERVAL_CHECK_EN
        e0 = err_seen;
        pulse_start();
        repeat (5) @(negedge clk);
        send_char(8'h57, 100, 1'b0);
        repeat (10) @(negedge clk);
        chk("x57_err", err_seen - e0, 1);
        chk("x57_divisor", divisor, 326);
`endif

        // Reset asserted in the middle of a measurement
        pulse_start();
        repeat (5) @(negedge clk);
        rx = 0; repeat (50) @(negedge clk);
        rx = 1; repeat (50) @(negedge clk);
        rx = 0; repeat (20) @(negedge clk);
        reset = 1;
        #1;
        chk("midrst_divisor", divisor, 27);
        chk("midrst_busy", busy, 0);
        chk("midrst_locked", locked, 0);
        rx = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (60) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
